// File: rtl/fft_tf_sequencer_pkg.sv
// Shared types and the twiddle address rule for the FFT twiddle sequencer.
// The address helper is reused by anything that needs a reference address.
package fft_tf_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } tf_state_e;

   // Stage s uses W^(j * 2^(LOG_N-1-s)) with j = b mod 2^s.
   function automatic logic [31:0] tf_addr(input logic [31:0] log_n,
                                           input logic [31:0] s,
                                           input logic [31:0] b);
      logic [31:0] mask;
      mask = (32'd1 << s) - 32'd1;
      return (b & mask) << (log_n - 32'd1 - s);
   endfunction

endpackage

// File: rtl/fft_tf_sequencer_if.sv
// Control and twiddle-stream bundle between FFT control, the sequencer and the butterfly.
interface fft_tf_sequencer_if #(
   parameter int TF_ADDR_LEN = 12,
   parameter int STAGE_W     = 4
);
   // start/abort are single-cycle strobes from control. The twiddle stream has no
   // backpressure after the ROM: ready gates rom_en in the same cycle, and tf_valid
   // follows one cycle later with the ROM data; no data is lost because b only
   // advances on a cycle where rom_en is high.
   logic                   start;
   logic                   abort;
   logic                   ready;
   logic                   rom_en;
   logic [TF_ADDR_LEN-1:0] rom_addr;
   logic                   tf_valid;
   logic [STAGE_W-1:0]     tf_stage;
   logic                   tf_last;
   logic                   busy;
   logic                   done;

   modport master (
      output start, abort, ready,
      input  rom_en, rom_addr, tf_valid, tf_stage, tf_last, busy, done
   );

   modport slave (
      input  start, abort, ready,
      output rom_en, rom_addr, tf_valid, tf_stage, tf_last, busy, done
   );
endinterface

// File: rtl/fft_tf_sequencer_addr_gen.sv
// Combinational twiddle ROM address from the stage and butterfly counters.
module fft_tf_addr_gen
   import fft_tf_sequencer_pkg::*;
#(
   parameter int LOG_N       = 13,
   parameter int TF_ADDR_LEN = 12,
   parameter int STAGE_W     = 4
) (
   input  logic [STAGE_W-1:0]     s,
   input  logic [LOG_N-2:0]       b,
   output logic [TF_ADDR_LEN-1:0] addr
);
   logic [31:0] full;
   logic        unused_hi;

   assign full      = tf_addr(32'(LOG_N), {{(32-STAGE_W){1'b0}}, s}, {{(32-(LOG_N-1)){1'b0}}, b});
   assign addr      = full[TF_ADDR_LEN-1:0];
   assign unused_hi = ^full[31:TF_ADDR_LEN];
endmodule

// File: rtl/fft_tf_sequencer.sv
// Twiddle-factor read scheduler for a radix-2 DIT FFT: walks stages and butterflies,
// drives the shared twiddle ROM and tags the returning data for the butterfly.
module fft_tf_sequencer
   import fft_tf_sequencer_pkg::*;
#(
   parameter int LOG_N       = 13,
   parameter int TF_ADDR_LEN = 12,
   parameter int STAGE_W     = 4,
   parameter int STAGE_FIRST = 0,
   parameter int STAGE_LAST  = 12,
   parameter int STAGE_GAP   = 4
) (
   input  logic                clk,
   input  logic                rst,
   fft_tf_sequencer_if.slave   bus,
   output tf_state_e           dbg_state
);
   localparam int B_W   = LOG_N - 1;
   localparam int GAP_W = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;
   localparam logic [GAP_W-1:0]   GAP_END = GAP_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
   localparam logic [STAGE_W-1:0] S_FIRST = STAGE_W'(STAGE_FIRST);
   localparam logic [STAGE_W-1:0] S_LAST  = STAGE_W'(STAGE_LAST);
   localparam logic [B_W-1:0]     B_LAST  = '1;

   tf_state_e              state, state_nx;
   logic [STAGE_W-1:0]     s, s_nx;
   logic [B_W-1:0]         b, b_nx;
   logic [GAP_W-1:0]       gap_cnt, gap_nx;
   logic                   issue;
   logic                   last_b;
   logic                   tf_valid_q, tf_last_q, done_q;
   logic [STAGE_W-1:0]     tf_stage_q;
   logic [TF_ADDR_LEN-1:0] rom_addr;

   assign last_b = (b == B_LAST);

   always_comb begin
      state_nx = state;
      s_nx     = s;
      b_nx     = b;
      gap_nx   = gap_cnt;
      issue    = 1'b0;
      if (bus.abort) begin
         state_nx = ST_IDLE;
         s_nx     = S_FIRST;
         b_nx     = '0;
         gap_nx   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state_nx = ST_RUN;
                  s_nx     = S_FIRST;
                  b_nx     = '0;
               end
            end
            ST_RUN: begin
               if (bus.ready) begin
                  issue = 1'b1;
                  b_nx  = b + B_W'(1);
                  if (last_b) begin
                     if (s == S_LAST) begin
                        state_nx = ST_DONE;
                     end else begin
                        s_nx     = s + STAGE_W'(1);
                        state_nx = (STAGE_GAP > 0) ? ST_GAP : ST_RUN;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_END) begin
                  gap_nx   = '0;
                  state_nx = ST_RUN;
               end else begin
                  gap_nx = gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state_nx = ST_IDLE;
               s_nx     = S_FIRST;
            end
         endcase
      end
   end

   // Everything below is delayed by the ROM's one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         s          <= S_FIRST;
         b          <= '0;
         gap_cnt    <= '0;
         tf_valid_q <= 1'b0;
         tf_stage_q <= '0;
         tf_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         s          <= s_nx;
         b          <= b_nx;
         gap_cnt    <= gap_nx;
         tf_valid_q <= issue;
         tf_stage_q <= issue ? s : tf_stage_q;
         tf_last_q  <= issue && last_b;
         done_q     <= issue && last_b && (s == S_LAST);
      end
   end

   fft_tf_addr_gen #(
      .LOG_N       (LOG_N),
      .TF_ADDR_LEN (TF_ADDR_LEN),
      .STAGE_W     (STAGE_W)
   ) u_addr_gen (
      .s    (s),
      .b    (b),
      .addr (rom_addr)
   );

   assign bus.rom_en   = issue;
   assign bus.rom_addr = rom_addr;
   assign bus.tf_valid = tf_valid_q;
   assign bus.tf_stage = tf_stage_q;
   assign bus.tf_last  = tf_last_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state == ST_RUN) || (state == ST_GAP);
   assign dbg_state    = state;
endmodule

// File: doc/fft_tf_sequencer.md
Name: fft_tf_sequencer

Overview:
- Schedules twiddle-factor reads for a radix-2 DIT FFT of 2^LOG_N points across the programmed stage range.
- Drives one shared twiddle ROM of N/2 entries (W^k, k = 0..N/2-1, 1-cycle read latency, output held while ena = 0).
- Emits per-butterfly address, enable, valid, stage tag and last flags to the butterfly datapath.
- Sits between the FFT top-level control (start/done) and the twiddle ROM / butterfly pipeline.

Parameters:
- LOG_N, 13, log2 of FFT length (N = 8192).
- TF_ADDR_LEN, 12, twiddle ROM address width; must equal LOG_N-1.
- STAGE_W, 4, width of the stage index; 2^STAGE_W >= LOG_N.
- STAGE_FIRST, 0, first stage scheduled.
- STAGE_LAST, 12, last stage scheduled; STAGE_FIRST <= STAGE_LAST <= LOG_N-1.
- STAGE_GAP, 4, idle cycles inserted between stages for butterfly pipeline drain; 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a schedule; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- ready  in  1  downstream can accept a twiddle this cycle.
- rom_en  out  1  twiddle ROM read enable (ena).
- rom_addr  out  TF_ADDR_LEN  twiddle ROM address.
- tf_valid  out  1  ROM data valid; aligned with ROM douta.
- tf_stage  out  STAGE_W  stage of the twiddle currently valid.
- tf_last  out  1  last twiddle of its stage; qualified by tf_valid.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  one-cycle pulse after the final twiddle of STAGE_LAST is presented.

Behaviour:
- Reset values: all outputs 0; state IDLE; stage = STAGE_FIRST; b = 0; gap counter = 0.
- Counters:
  - stage counter s (STAGE_W bits).
  - butterfly counter b (LOG_N-1 bits, 0..N/2-1).
  - gap counter (width covering STAGE_GAP).
- Address rule: rom_addr = (b & (2^s - 1)) << (LOG_N-1-s), truncated to TF_ADDR_LEN. Combinational from the registered s and b. Stage 0 gives all zeros; stage LOG_N-1 gives b.
- Issue: issue = (state == RUN) && ready && !abort. rom_en = issue (combinational). b increments only on issue.
- Stall: with ready = 0, rom_en = 0 and b holds. The ROM output holds. tf_valid drops to 0 the following cycle.
- Registered outputs:
  - tf_valid <= issue.
  - tf_stage <= s at issue.
  - tf_last <= issue && (b == N/2-1).
  - Latency from issue to tf_valid is 1 cycle.
- State machine (IDLE, RUN, GAP, DONE):
  - IDLE: on start, go to RUN with s = STAGE_FIRST and b = 0.
  - RUN: an issue with b == N/2-1 wraps b to 0. If s == STAGE_LAST, go to DONE. Otherwise increment s, then go to GAP if STAGE_GAP > 0, else stay in RUN.
  - GAP: count STAGE_GAP cycles with no issue, then return to RUN.
  - DONE: one cycle; done = 1 (registered, coincident with the tf_valid of the final twiddle); then IDLE.
- busy = (state == RUN) || (state == GAP).
- Simultaneous events:
  - start while not IDLE is ignored.
  - abort has priority over start and issue. From any state, go to IDLE next cycle, reset counters, no done pulse. A tf_valid already registered for the abort cycle's prior issue still appears.
  - start and abort together in IDLE: stay IDLE.
- Back-to-back runs: start in the DONE cycle is ignored. start is accepted from the first IDLE cycle.
- Asynchronous rst mid-run returns everything to reset values immediately.
- Throughput with ready held high: N/2 issues per stage plus STAGE_GAP cycles between stages.

Decomposition:
- Shared package:
  - State encoding constants (IDLE = 0, RUN = 1, GAP = 2, DONE = 3).
  - Helper function for the twiddle address rule, also used by the bench reference model.
- Natural sub-module: fft_tf_addr_gen. Combinational; takes s and b, returns rom_addr; independently testable.
- ROM instance lives outside this block.

Test Plan:
1. LOG_N = 4, STAGE_GAP = 0, ready = 1, pulse start -> issued addresses:
   - stage 0: 0,0,0,0,0,0,0,0
   - stage 1: 0,4,0,4,0,4,0,4
   - stage 2: 0,2,4,6,0,2,4,6
   - stage 3: 0,1,2,3,4,5,6,7
   - tf_last on issues 8, 16, 24, 32; done 33 cycles after the RUN entry cycle.
2. Same config, ready toggled 1,0,1,0 -> rom_en equals ready in RUN; tf_valid lags rom_en by 1 cycle; address sequence unchanged; 64 RUN cycles total.
3. LOG_N = 4, STAGE_GAP = 3 -> exactly 3 cycles with rom_en = 0 and busy = 1 between stages; tf_stage steps 0,1,2,3.
4. abort asserted at stage 2, b = 5 -> IDLE next cycle; busy = 0; no done; a new start restarts at stage 0 with address 0.
5. start during RUN, and start together with abort in IDLE -> both ignored; counters undisturbed.
6. rst asserted asynchronously mid-stage 1 -> all outputs 0 within the same cycle, before the next clk edge; after release, IDLE; next start yields the full sequence of scenario 1.
